// File: rtl/dm_access_unit.sv
// MEM-stage access unit for the word-wide big-endian data memory: word-aligned reads/writes, RMW sub-word stores.
// Optional DM_ACCESS_BOUNDS_CHECK_EN: out-of-range addresses error out instead of wrapping modulo DATA_MEM_SIZE.
module dm_access_unit #(
  parameter int DATA_MEM_SIZE = 128,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       MemReadData
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_e;
  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] eff_addr;
  logic              out_of_range;
  logic              misaligned;

`ifdef DM_ACCESS_BOUNDS_CHECK_EN
  assign eff_addr     = req_addr;
  assign out_of_range = (req_addr >= ADDR_W'(DATA_MEM_SIZE));
`else
  assign eff_addr     = req_addr % ADDR_W'(DATA_MEM_SIZE);
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    misaligned = 1'b0;
    case (op_e'(req_op))
      OP_LW, OP_SW:          misaligned = (eff_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misaligned = eff_addr[0];
      default:               misaligned = 1'b0;
    endcase
  end

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  function automatic logic [31:0] load_extract(input op_e op, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {~off, 3'b000});
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input op_e op, input logic [1:0] off,
                                              input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] mask;
    mask = 32'h0000_00FF << {~off, 3'b000};
    if (op == OP_SH)
      return off[1] ? {word[31:16], wd[15:0]} : {wd[15:0], word[15:0]};
    return (word & ~mask) | ((32'(wd[7:0])) << {~off, 3'b000});
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d       = op_e'(req_op);
          off_d      = eff_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {eff_addr[ADDR_W-1:2], 2'b00};
          rdata_d    = 32'h0;
          err_d      = 1'b0;
          if (misaligned || out_of_range) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (op_e'(req_op) == OP_SW) begin
            mem_wdata_d = req_wdata;
            state_d     = WR;
          end else if (op_e'(req_op) inside {OP_SH, OP_SB}) begin
            state_d = RMW_RD;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        rdata_d = load_extract(op_q, off_q, MemReadData);
        state_d = RESP;
      end
      RMW_RD: begin
        mem_wdata_d = store_merge(op_q, off_q, MemReadData, wdata_q);
        state_d     = WR;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_LW;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Strobes are gated by rst directly so a reset in WR suppresses the write in that same cycle.
  assign MemRead      = ((state_q == RD) || (state_q == RMW_RD)) && !rst;
  assign MemWrite     = (state_q == WR) && !rst;
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign MemAddr      = mem_addr_q;
  assign MemWriteData = mem_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: directed cases plus random traffic against a byte-array reference model.
// Honours DM_ACCESS_BOUNDS_CHECK_EN in its expectations.
module tb_dm_access_unit;

  localparam int SIZE   = 128;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWriteData;
  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       MemReadData = 32'h0;

  dm_access_unit #(.DATA_MEM_SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] dm_mem [0:SIZE/4-1];
  logic [7:0]  ref_b  [0:SIZE-1];

  // Environment memory: samples strobes on the falling edge.
  always @(negedge clk) begin
    if (MemRead)  MemReadData <= dm_mem[MemAddr[6:2]];
    if (MemWrite) dm_mem[MemAddr[6:2]] <= MemWriteData;
  end

  int          last_lat, last_rd, last_wr;
  logic [31:0] last_waddr, last_wdata, last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    dm_mem[a/4] = w;
    for (int i = 0; i < 4; i++) ref_b[a + i] = 8'(w >> (8 * (3 - i)));
  endtask

  function automatic logic [31:0] ref_word(input int wi);
    return {ref_b[4*wi], ref_b[4*wi+1], ref_b[4*wi+2], ref_b[4*wi+3]};
  endfunction

  // Reference: byte-granular big-endian memory, plain arithmetic.
  task automatic ref_access(input int op, input int unsigned addr, input logic [31:0] wd,
                            output logic [31:0] e_rdata, output logic e_err,
                            output int e_lat, output int e_rd, output int e_wr);
    int unsigned ea;
    int size;
    bit load, sgn;
    logic [31:0] v;
    size  = (op == 0 || op == 5) ? 4 : (op == 1 || op == 2 || op == 6) ? 2 : 1;
    load  = (op < 5);
    sgn   = (op == 1 || op == 3);
    e_err = 1'b0;
`ifdef DM_ACCESS_BOUNDS_CHECK_EN
    ea = addr;
    if (addr >= SIZE) e_err = 1'b1;
`else
    ea = addr % SIZE;
`endif
    if ((ea % size) != 0) e_err = 1'b1;
    e_rdata = 32'h0;
    if (e_err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (load) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = (v << 8) | 32'(ref_b[ea + i]);
      if (sgn && v[8*size-1]) v = v - (32'd1 << (8 * size));
      e_rdata = v;
      e_lat = 2; e_rd = 1; e_wr = 0;
    end else begin
      for (int i = 0; i < size; i++) ref_b[ea + i] = 8'(wd >> (8 * (size - 1 - i)));
      e_lat = (size == 4) ? 2 : 3;
      e_rd  = (size == 4) ? 0 : 1;
      e_wr  = 1;
    end
  endtask

  // Called at the sample point just after the accept edge; follows the access to resp_valid.
  task automatic wait_resp(input string tag);
    last_lat = 1; last_rd = 0; last_wr = 0;
    forever begin
      check({tag, " rw_excl"}, 32'(MemRead & MemWrite), 32'h0);
      check({tag, " busy_ready"}, 32'(req_ready), 32'h0);
      if (MemRead) last_rd++;
      if (MemWrite) begin
        last_wr++;
        last_waddr = MemAddr;
        last_wdata = MemWriteData;
      end
      if (resp_valid || last_lat >= 8) break;
      @(posedge clk); #1;
      last_lat++;
    end
    check({tag, " resp_seen"}, 32'(resp_valid), 32'h1);
    last_rdata = resp_rdata;
    last_err   = resp_err;
  endtask

  task automatic compare_to_ref(input string tag, input int op, input logic [31:0] addr,
                                input logic [31:0] wd);
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat, e_rd, e_wr;
    ref_access(op, addr, wd, e_rdata, e_err, e_lat, e_rd, e_wr);
    check({tag, " rdata"},  last_rdata, e_rdata);
    check({tag, " err"},    32'(last_err), 32'(e_err));
    check({tag, " latency"}, 32'(last_lat), 32'(e_lat));
    check({tag, " reads"},  32'(last_rd), 32'(e_rd));
    check({tag, " writes"}, 32'(last_wr), 32'(e_wr));
  endtask

  // One isolated request from an idle sample point, back to idle afterwards.
  task automatic do_op(input int op, input logic [31:0] addr, input logic [31:0] wd);
    string tag;
    tag = $sformatf("op%0d@%h", op, addr);
    check({tag, " idle_ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_op = 3'(op); req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(tag);
    compare_to_ref(tag, op, addr, wd);
    @(posedge clk); #1;
    check({tag, " resp_pulse"}, 32'(resp_valid), 32'h0);
    check({tag, " ready_after"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = 32'h0;
    for (int w = 0; w < SIZE/4; w++) set_word(4*w, $urandom);
    set_word(32'h20, 32'h80FF7F01);
    set_word(32'h10, 32'h11223344);
    repeat (2) @(posedge clk);
    #1;
    check("rst MemRead",  32'(MemRead), 32'h0);
    check("rst MemWrite", 32'(MemWrite), 32'h0);
    rst = 1'b0;
    #1;
    check("rst req_ready",    32'(req_ready), 32'h1);
    check("rst resp_valid",   32'(resp_valid), 32'h0);
    check("rst resp_rdata",   resp_rdata, 32'h0);
    check("rst resp_err",     32'(resp_err), 32'h0);
    check("rst MemAddr",      MemAddr, 32'h0);
    check("rst MemWriteData", MemWriteData, 32'h0);

    // Sub-word loads from 0x80FF7F01
    do_op(3, 32'h20, 32'h0); check("LB 0x20 const",  last_rdata, 32'hFFFFFF80);
    do_op(4, 32'h20, 32'h0); check("LBU 0x20 const", last_rdata, 32'h00000080);
    do_op(1, 32'h20, 32'h0); check("LH 0x20 const",  last_rdata, 32'hFFFF80FF);
    do_op(2, 32'h22, 32'h0); check("LHU 0x22 const", last_rdata, 32'h00007F01);

    // Read-modify-write stores into 0x11223344
    do_op(7, 32'h11, 32'h000000AB);
    check("SB waddr", last_waddr, 32'h10);
    check("SB wdata", last_wdata, 32'h11AB3344);
    do_op(0, 32'h10, 32'h0); check("LW after SB", last_rdata, 32'h11AB3344);
    do_op(6, 32'h12, 32'h0000BEEF);
    do_op(0, 32'h10, 32'h0); check("LW after SH", last_rdata, 32'h11ABBEEF);

    // Misaligned accesses
    do_op(6, 32'h13, 32'h12345678);
    do_op(0, 32'h02, 32'h0);
    check("misaligned mem", dm_mem[4], 32'h11ABBEEF);

    // Back-to-back SW then LW with req_valid held high
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h7C; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_op = 3'd0;
    wait_resp("b2b SW");
    compare_to_ref("b2b SW", 5, 32'h7C, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("b2b ready_idle", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    check("b2b accepted", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    wait_resp("b2b LW");
    compare_to_ref("b2b LW", 0, 32'h7C, 32'h0);
    check("b2b LW const", last_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset during the write phase of an SB
    req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h10; req_wdata = 32'h0000005A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstwr MemRead", 32'(MemRead), 32'h1);
    @(posedge clk); #1;
    check("rstwr MemWrite pre", 32'(MemWrite), 32'h1);
    rst = 1'b1;
    #1;
    check("rstwr MemWrite gated", 32'(MemWrite), 32'h0);
    check("rstwr MemRead gated",  32'(MemRead), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwr ready", 32'(req_ready), 32'h1);
    for (int c = 0; c < 3; c++) begin
      check("rstwr no_resp", 32'(resp_valid), 32'h0);
      @(posedge clk); #1;
    end
    check("rstwr mem kept", dm_mem[4], ref_word(4));
    check("rstwr mem const", dm_mem[4], 32'h11ABBEEF);

    // Out-of-range: wraps by default, errors with the bounds check
    do_op(0, 32'h84, 32'h0);
    do_op(0, 32'h80, 32'h0);
    do_op(5, 32'h90, 32'hCAFEF00D);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, SIZE + 31));
      if ($urandom_range(0, 3) != 0) a = a & ~32'((op == 1 || op == 2 || op == 6) ? 1 : 3);
      do_op(op, a, $urandom);
    end

    for (int w = 0; w < SIZE/4; w++) check($sformatf("final word %0d", w), dm_mem[w], ref_word(w));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- MEM-stage initiator for the word-wide, big-endian data memory (DM).
- Converts pipeline load/store requests (LW/LH/LHU/LB/LBU/SW/SH/SB) into word-aligned DM reads and writes.
- Sub-word stores are done as read-modify-write. Sub-word loads are extracted with sign or zero extension.
- Holds the pipeline through a valid/ready handshake until each access completes.

Parameters:
DATA_MEM_SIZE, 128, DM size in bytes; must be a multiple of 4.
ADDR_W, 32, width of the pipeline address and the DM address.

Ports:
clk  input  1  clock, rising-edge; DM samples on the falling edge of the same clock
rst  input  1  synchronous active-high reset
req_valid  input  1  pipeline request strobe
req_ready  output  1  unit idle and able to accept a request
req_op  input  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data; SB uses [7:0], SH uses [15:0]
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load result; 0 for stores and errors
resp_err  output  1  qualified by resp_valid; misaligned or out-of-range access
MemAddr  output  ADDR_W  word-aligned DM address; [1:0] is always 0
MemWriteData  output  32  DM write word
MemRead  output  1  DM read enable
MemWrite  output  1  DM write enable
MemReadData  input  32  DM read word; valid after the falling edge of a MemRead cycle

Behaviour:
- States: IDLE, RD, RMW_RD, WR, RESP. Reset state is IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemAddr=0, MemWriteData=0.
- MemRead = (state==RD or RMW_RD) and !rst. MemWrite = (state==WR) and !rst.
- MemRead and MemWrite are never high together.
- IDLE, accepting a request (req_valid and req_ready):
  - Latch op, addr and wdata. Set MemAddr = {addr[ADDR_W-1:2],2'b00}.
  - Misaligned access goes to RESP with err=1. Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1.
  - Otherwise loads go to RD, SW goes to WR with MemWriteData=wdata, and SB/SH go to RMW_RD.
- req_ready is 1 only in IDLE. A request arriving while busy is not accepted; the pipeline holds req_* stable.
- RD: DM read. At the next rising edge, capture MemReadData, extract, then go to RESP.
- Extraction (big-endian, byte offset 0 = bits [31:24]):
  - Byte k = word[31-8k -: 8].
  - Halfword at offset 0 = [31:16]; at offset 2 = [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RMW_RD: DM read. At the next rising edge, build MemWriteData from MemReadData with the target byte or halfword replaced by wdata, then go to WR.
- WR: DM write. The next rising edge goes to RESP.
- RESP: resp_valid=1 for exactly one cycle, then back to IDLE with req_ready=1. A new request is accepted the cycle after RESP.
- Latency, measured from the accept edge to resp_valid high: error = 1 cycle, LW/LH/LB/SW = 2 cycles, SB/SH = 3 cycles.
- Reset mid-operation: MemRead and MemWrite drop within the same cycle, so a reset asserted during WR suppresses the DM write. The state returns to IDLE. No resp_valid is issued for the aborted request.

Optional Feature:
- Macro: DM_ACCESS_BOUNDS_CHECK_EN.
- Defined: on accept, addr >= DATA_MEM_SIZE gives resp_err=1 after 1 cycle, with no DM access. Alignment errors take priority but produce the same response.
- Undefined: the address is reduced modulo DATA_MEM_SIZE before alignment, so accesses wrap. 0x84 with size 128 accesses 0x04.

Test Plan:
- DM word at 0x20 = 0x80FF7F01.
  - LB 0x20 -> 0xFFFFFF80. LBU 0x20 -> 0x00000080.
  - LH 0x20 -> 0xFFFF80FF. LHU 0x22 -> 0x00007F01.
  - Each completes 2 cycles after accept, with MemWrite=0 throughout.
- DM word at 0x10 = 0x11223344.
  - SB 0x11 with wdata 0x000000AB -> MemRead 1 cycle, then MemWrite 1 cycle with MemAddr=0x10 and MemWriteData=0x11AB3344; resp_valid 3 cycles after accept; LW 0x10 then returns 0x11AB3344.
  - SH 0x12 with wdata 0xBEEF -> word 0x11ABBEEF.
- SH 0x13 and LW 0x02 -> resp_err=1 and resp_valid 1 cycle after accept; MemRead=MemWrite=0 throughout; memory unchanged.
- SW 0x7C 0xDEADBEEF, then LW 0x7C back-to-back with req_valid held high -> req_ready low while busy; second request accepted the cycle after the first resp_valid; returns 0xDEADBEEF.
- SB 0x10 with rst pulsed in the WR cycle -> MemWrite=0 in that cycle; word at 0x10 unchanged; no resp_valid; req_ready=1 the next cycle.
- Bounds: with DM_ACCESS_BOUNDS_CHECK_EN, LW 0x80 -> resp_err=1 after 1 cycle. Without it, LW 0x84 reads DM word 0x04.
